// File: rtl/if_fetch_unit.sv
// if_fetch_unit
//   Fetch-stage producer for the IF/ID pipeline register. Owns the PC and
//   issues instruction-memory reads over a held-request interface: once
//   imem_read is raised, the read stays high and imem_address stays stable
//   until imem_resp arrives. Handles stalls from downstream and redirects
//   (branch/JMP/TRAP) that land while a read is in flight.
//
// Parameters
//   RESET_PC        PC value loaded on reset
//   NOP_INSTR       instruction presented when no valid fetch is available
//
// Ports
//   clk             clock, all state updates on the rising edge
//   reset           synchronous, active-high reset
//   stall           downstream hazard; IF/ID must hold
//   redirect_valid  one-cycle pulse: continue fetching at redirect_pc
//   redirect_pc     redirect target (bit 0 forced to 0)
//   imem_read       read request, held high until imem_resp
//   imem_address    read address, stable while a request is outstanding
//   imem_rdata      instruction data, valid in the imem_resp cycle
//   imem_resp       one-cycle response strobe
//   if_plus2_out    pc+2 of the presented instruction
//   if_instr_out    instruction for IF/ID; NOP_INSTR when nothing is valid
//   if_id_load      IF/ID load enable (= ~stall)
//
// Build option
//   FETCH_SKID_EN   when defined, a response that arrives under stall is parked
//                   in a one-entry hold buffer and presented once stall drops.
//                   When undefined, that response is discarded and the same
//                   address is refetched after the stall clears.

module if_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        imem_read,
    output logic [15:0] imem_address,
    input  logic [15:0] imem_rdata,
    input  logic        imem_resp,
    output logic [15:0] if_plus2_out,
    output logic [15:0] if_instr_out,
    output logic        if_id_load
);

    logic [15:0] pc_q, pc_d;
    logic [15:0] pending_pc_q, pending_pc_d;
    logic        squash_q, squash_d;
    // Set when reset lands on an in-flight read: the late response must be dropped.
    logic        stale_q, stale_d;
    // A read was presented last cycle and has not been answered yet.
    logic        outstanding_q;
    logic [15:0] redirect_target;
    logic        drop;

`ifdef FETCH_SKID_EN
    typedef enum logic [0:0] {StFetch, StHold} state_e;
    state_e      state_q, state_d;
    logic [15:0] hold_instr_q, hold_instr_d;
    logic [15:0] hold_pc_q, hold_pc_d;
`else
    // Response was discarded under stall; keep the bus idle until stall drops.
    logic        refetch_wait_q, refetch_wait_d;
`endif

    assign redirect_target = redirect_pc & 16'hFFFE;
    assign drop            = squash_q | stale_q | redirect_valid;

    always_comb begin
        pc_d         = pc_q;
        pending_pc_d = pending_pc_q;
        squash_d     = squash_q;
        stale_d      = stale_q;
        imem_read    = 1'b0;
        imem_address = pc_q;
        if_instr_out = NOP_INSTR;
        if_plus2_out = pc_q + 16'd2;
        if_id_load   = ~stall;
`ifdef FETCH_SKID_EN
        state_d      = state_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
`else
        refetch_wait_d = refetch_wait_q;
`endif

        if (reset) begin
            imem_address = RESET_PC;
            if_plus2_out = RESET_PC + 16'd2;
`ifdef FETCH_SKID_EN
        end else if (state_q == StHold) begin
            // Buffered instruction waits here with the bus idle.
            imem_read    = 1'b0;
            if_plus2_out = hold_pc_q + 16'd2;
            if (redirect_valid) begin
                pc_d    = redirect_target;
                state_d = StFetch;
            end else if (!stall) begin
                if_instr_out = hold_instr_q;
                pc_d         = hold_pc_q + 16'd2;
                state_d      = StFetch;
            end
`endif
        end else begin
            imem_read = 1'b1;
`ifndef FETCH_SKID_EN
            if (refetch_wait_q) begin
                if (stall) begin
                    imem_read = 1'b0;
                end else begin
                    refetch_wait_d = 1'b0;
                end
            end
`endif
            if (imem_resp) begin
                squash_d = 1'b0;
                stale_d  = 1'b0;
                if (drop) begin
                    if (redirect_valid) begin
                        pc_d = redirect_target;
                    end else if (squash_q) begin
                        pc_d = pending_pc_q;
                    end
                end else if (!stall) begin
                    if_instr_out = imem_rdata;
                    pc_d         = pc_q + 16'd2;
                end else begin
`ifdef FETCH_SKID_EN
                    hold_instr_d = imem_rdata;
                    hold_pc_d    = pc_q;
                    state_d      = StHold;
`else
                    refetch_wait_d = 1'b1;
`endif
                end
            end else if (redirect_valid) begin
                if (imem_read) begin
                    // Address must not move under an in-flight read; park the target.
                    pending_pc_d = redirect_target;
                    squash_d     = 1'b1;
                end else begin
                    pc_d = redirect_target;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            pending_pc_q  <= RESET_PC;
            squash_q      <= 1'b0;
            stale_q       <= (stale_q | outstanding_q) & ~imem_resp;
            outstanding_q <= 1'b0;
`ifdef FETCH_SKID_EN
            state_q       <= StFetch;
            hold_instr_q  <= 16'h0000;
            hold_pc_q     <= 16'h0000;
`else
            refetch_wait_q <= 1'b0;
`endif
        end else begin
            pc_q          <= pc_d;
            pending_pc_q  <= pending_pc_d;
            squash_q      <= squash_d;
            stale_q       <= stale_d;
            outstanding_q <= imem_read & ~imem_resp;
`ifdef FETCH_SKID_EN
            state_q       <= state_d;
            hold_instr_q  <= hold_instr_d;
            hold_pc_q     <= hold_pc_d;
`else
            refetch_wait_q <= refetch_wait_d;
`endif
        end
    end

`ifndef SYNTHESIS
    req_stable_a : assert property (@(posedge clk)
        (!reset && imem_read && !imem_resp) |=>
        (reset || (imem_read && $stable(imem_address))));

    resp_expected_a : assert property (@(posedge clk)
        (!reset && imem_resp) |-> (outstanding_q || stale_q));
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        imem_read;
    logic [15:0] imem_address;
    logic [15:0] imem_rdata = 16'h0000;
    logic        imem_resp = 1'b0;
    logic [15:0] if_plus2_out;
    logic [15:0] if_instr_out;
    logic        if_id_load;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .RESET_PC  (16'h0000),
        .NOP_INSTR (16'h0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_read      (imem_read),
        .imem_address   (imem_address),
        .imem_rdata     (imem_rdata),
        .imem_resp      (imem_resp),
        .if_plus2_out   (if_plus2_out),
        .if_instr_out   (if_instr_out),
        .if_id_load     (if_id_load)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        rv;
        logic [15:0] rpc;
        logic        resp;
        logic [15:0] rdata;
        logic        e_read;
        logic [15:0] e_addr;
        logic [15:0] e_instr;
        logic [15:0] e_plus2;
        logic        e_load;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic stl, input logic rv,
                                input logic [15:0] rpc, input logic resp,
                                input logic [15:0] rdata, input logic e_read,
                                input logic [15:0] e_addr, input logic [15:0] e_instr,
                                input logic [15:0] e_plus2);
        vec_t v;
        v.rst = rst; v.stall = stl; v.rv = rv; v.rpc = rpc;
        v.resp = resp; v.rdata = rdata;
        v.e_read = e_read; v.e_addr = e_addr; v.e_instr = e_instr;
        v.e_plus2 = e_plus2; v.e_load = ~stl;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of inputs after the rising edge, compare on the falling edge.
    task automatic run_vec(input vec_t v, input int idx);
        @(posedge clk);
        #1;
        reset          = v.rst;
        stall          = v.stall;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        imem_resp      = v.resp;
        imem_rdata     = v.rdata;
        #4;
        chk("imem_read", idx, {15'h0, imem_read}, {15'h0, v.e_read});
        chk("imem_address", idx, imem_address, v.e_addr);
        chk("if_instr_out", idx, if_instr_out, v.e_instr);
        chk("if_plus2_out", idx, if_plus2_out, v.e_plus2);
        chk("if_id_load", idx, {15'h0, if_id_load}, {15'h0, v.e_load});
    endtask

    initial begin
        // Reset, then sequential fetch with 1-cycle memory
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0002));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0002));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0002));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h1234, 1, 16'h0000, 16'h1234, 16'h0002));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0002, 16'h0000, 16'h0004));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h5678, 1, 16'h0002, 16'h5678, 16'h0004));
        // Redirect between read and resp: address holds, data dropped
        tbl.push_back(mk(0, 0, 1, 16'h3000, 0, 16'h0000, 1, 16'h0004, 16'h0000, 16'h0006));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 16'hBEEF, 1, 16'h0004, 16'h0000, 16'h0006));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h3000, 16'h0000, 16'h3002));
        // Redirect in the resp cycle, odd target gets bit 0 cleared
        tbl.push_back(mk(0, 0, 1, 16'h4001, 1, 16'h1111, 1, 16'h3000, 16'h0000, 16'h3002));
        // Two redirects while pending: last one wins
        tbl.push_back(mk(0, 0, 1, 16'h5000, 0, 16'h0000, 1, 16'h4000, 16'h0000, 16'h4002));
        tbl.push_back(mk(0, 0, 1, 16'h0011, 0, 16'h0000, 1, 16'h4000, 16'h0000, 16'h4002));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h2222, 1, 16'h4000, 16'h0000, 16'h4002));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0010, 16'h0000, 16'h0012));
        // Three stall cycles across resp of ABCD at 0x10
        tbl.push_back(mk(0, 1, 0, 16'h0000, 1, 16'hABCD, 1, 16'h0010, 16'h0000, 16'h0012));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0010, 16'h0000, 16'h0012));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0010, 16'h0000, 16'h0012));
`ifdef FETCH_SKID_EN
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0010, 16'hABCD, 16'h0012));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0012, 16'h0000, 16'h0014));
`else
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0010, 16'h0000, 16'h0012));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 16'hABCD, 1, 16'h0010, 16'hABCD, 16'h0012));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0012, 16'h0000, 16'h0014));
`endif
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h4444, 1, 16'h0012, 16'h4444, 16'h0014));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0014, 16'h0000, 16'h0016));
        // Resp under stall, then redirect while still stalled
        tbl.push_back(mk(0, 1, 0, 16'h0000, 1, 16'hCCCC, 1, 16'h0014, 16'h0000, 16'h0016));
        tbl.push_back(mk(0, 1, 1, 16'h2000, 0, 16'h0000, 0, 16'h0014, 16'h0000, 16'h0016));
`ifdef FETCH_SKID_EN
        tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h2000, 16'h0000, 16'h2002));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h5555, 1, 16'h2000, 16'h5555, 16'h2002));
`else
        tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h2000, 16'h0000, 16'h2002));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h2000, 16'h0000, 16'h2002));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h5555, 1, 16'h2000, 16'h5555, 16'h2002));
`endif
        // PC wrap at 0xFFFE
        tbl.push_back(mk(0, 0, 1, 16'hFFFF, 0, 16'h0000, 1, 16'h2002, 16'h0000, 16'h2004));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h9999, 1, 16'h2002, 16'h0000, 16'h2004));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'hFFFE, 16'h0000, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h7777, 1, 16'hFFFE, 16'h7777, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0002));

        foreach (tbl[i]) run_vec(tbl[i], i);

        // Reset lands on an in-flight read at 0x0400; its late resp must be ignored.
        run_vec(mk(0, 0, 1, 16'h0400, 0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0002), 100);
        run_vec(mk(0, 0, 0, 16'h0000, 1, 16'h0101, 1, 16'h0000, 16'h0000, 16'h0002), 101);
        run_vec(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0400, 16'h0000, 16'h0402), 102);
        run_vec(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0002), 103);
        run_vec(mk(0, 0, 0, 16'h0000, 1, 16'h0BAD, 1, 16'h0000, 16'h0000, 16'h0002), 104);
        run_vec(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0002), 105);
        run_vec(mk(0, 0, 0, 16'h0000, 1, 16'h1234, 1, 16'h0000, 16'h1234, 16'h0002), 106);
        run_vec(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0002, 16'h0000, 16'h0004), 107);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1);
    end

endmodule
